// File: rtl/mips_pkg.sv
// MIPS encoding constants shared by the decode/operand stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Stores and branches write nothing; index 0 keeps downstream forwarding inert.
    function automatic logic [4:0] dest_index(input logic [5:0] op,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
        logic [4:0] dst;
        case (op)
            OP_RTYPE:              dst = rd;
            OP_JAL:                dst = LINK_REG;
            OP_SW, OP_BEQ, OP_BNE: dst = 5'd0;
            default:               dst = rt;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: r0 is zero, a same-cycle write-back wins over the register file.
module operand_bypass #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] val
);

    always_comb begin
        val = rf_data;
        if (idx == '0) begin
            val = '0;
        end else if (wb_en && (wb_addr == idx)) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: reads the register file, bypasses write-back,
// interlocks on load-use and registers the result into the ID/EX register.
module id_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              id_ready,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    output logic [ADDR_W-1:0] rf_rd_addr2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs_addr,
    output logic [ADDR_W-1:0] ex_rt_addr,
    output logic [ADDR_W-1:0] ex_dst_addr,
    output logic              ex_is_load
);

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs_idx, rt_idx, dst_idx;
    logic [DATA_W-1:0] rs_val, rt_val, imm_sext;
    logic              hazard, out_free, accept;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [5:0]        ex_opcode_q, ex_opcode_d;
    logic [5:0]        ex_funct_q, ex_funct_d;
    logic [4:0]        ex_shamt_q, ex_shamt_d;
    logic [DATA_W-1:0] ex_rs_val_q, ex_rs_val_d;
    logic [DATA_W-1:0] ex_rt_val_q, ex_rt_val_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [ADDR_W-1:0] ex_rs_addr_q, ex_rs_addr_d;
    logic [ADDR_W-1:0] ex_rt_addr_q, ex_rt_addr_d;
    logic [ADDR_W-1:0] ex_dst_addr_q, ex_dst_addr_d;
    logic              ex_is_load_q, ex_is_load_d;

    assign opcode   = if_instr[OPC_MSB:OPC_LSB];
    assign rs_idx   = ADDR_W'(if_instr[RS_MSB:RS_LSB]);
    assign rt_idx   = ADDR_W'(if_instr[RT_MSB:RT_LSB]);
    assign dst_idx  = ADDR_W'(dest_index(opcode, if_instr[RT_MSB:RT_LSB], if_instr[RD_MSB:RD_LSB]));
    assign imm_sext = {{(DATA_W-16){if_instr[IMM_MSB]}}, if_instr[IMM_MSB:IMM_LSB]};

    assign rf_rd_addr1 = rs_idx;
    assign rf_rd_addr2 = rt_idx;

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_rs (
        .idx(rs_idx), .rf_data(rf_rd_data1), .wb_en(wb_wr_en),
        .wb_addr(wb_wr_addr), .wb_data(wb_wr_data), .val(rs_val)
    );

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_rt (
        .idx(rt_idx), .rf_data(rf_rd_data2), .wb_en(wb_wr_en),
        .wb_addr(wb_wr_addr), .wb_data(wb_wr_data), .val(rt_val)
    );

    // The load result is not available until after EX, so a dependent must wait one slot.
    assign hazard   = ex_valid_q && ex_is_load_q && (ex_dst_addr_q != '0) &&
                      ((ex_dst_addr_q == rs_idx) || (ex_dst_addr_q == rt_idx));
    assign out_free = ~ex_valid_q | ex_ready;
    assign id_ready = out_free & ~hazard & ~flush;
    assign accept   = if_valid & id_ready;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct_d    = ex_funct_q;
        ex_shamt_d    = ex_shamt_q;
        ex_rs_val_d   = ex_rs_val_q;
        ex_rt_val_d   = ex_rt_val_q;
        ex_imm_d      = ex_imm_q;
        ex_rs_addr_d  = ex_rs_addr_q;
        ex_rt_addr_d  = ex_rt_addr_q;
        ex_dst_addr_d = ex_dst_addr_q;
        ex_is_load_d  = ex_is_load_q;
        if (flush || out_free) begin
            ex_valid_d = accept;
        end
        if (accept) begin
            ex_pc_d       = if_pc;
            ex_opcode_d   = opcode;
            ex_funct_d    = if_instr[FUNCT_MSB:FUNCT_LSB];
            ex_shamt_d    = if_instr[SHAMT_MSB:SHAMT_LSB];
            ex_rs_val_d   = rs_val;
            ex_rt_val_d   = rt_val;
            ex_imm_d      = imm_sext;
            ex_rs_addr_d  = rs_idx;
            ex_rt_addr_d  = rt_idx;
            ex_dst_addr_d = dst_idx;
            ex_is_load_d  = (opcode == OP_LW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_opcode_q   <= '0;
            ex_funct_q    <= '0;
            ex_shamt_q    <= '0;
            ex_rs_val_q   <= '0;
            ex_rt_val_q   <= '0;
            ex_imm_q      <= '0;
            ex_rs_addr_q  <= '0;
            ex_rt_addr_q  <= '0;
            ex_dst_addr_q <= '0;
            ex_is_load_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct_q    <= ex_funct_d;
            ex_shamt_q    <= ex_shamt_d;
            ex_rs_val_q   <= ex_rs_val_d;
            ex_rt_val_q   <= ex_rt_val_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs_addr_q  <= ex_rs_addr_d;
            ex_rt_addr_q  <= ex_rt_addr_d;
            ex_dst_addr_q <= ex_dst_addr_d;
            ex_is_load_q  <= ex_is_load_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_opcode   = ex_opcode_q;
    assign ex_funct    = ex_funct_q;
    assign ex_shamt    = ex_shamt_q;
    assign ex_rs_val   = ex_rs_val_q;
    assign ex_rt_val   = ex_rt_val_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs_addr  = ex_rs_addr_q;
    assign ex_rt_addr  = ex_rt_addr_q;
    assign ex_dst_addr = ex_dst_addr_q;
    assign ex_is_load  = ex_is_load_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with a stub register file and hand-computed expectations.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic [4:0]  rf_rd_addr1, rf_rd_addr2;
    logic [31:0] rf_rd_data1, rf_rd_data2;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_shamt, ex_rs_addr, ex_rt_addr, ex_dst_addr;
    logic        ex_is_load;

    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];

    id_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2), .wb_wr_en(wb_wr_en),
        .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_shamt(ex_shamt), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dst_addr(ex_dst_addr),
        .ex_is_load(ex_is_load)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd9;
        rf[4] = 32'd7;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_data = '0; flush = 1'b0; ex_ready = 1'b1;
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_rs_val", ex_rs_val, 32'd0);
        chk("rst_dst", 32'(ex_dst_addr), 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD r3,r1,r2
        offer(32'h00221820, 32'h100);
        #1;
        chk("rd_addr1", 32'(rf_rd_addr1), 32'd1);
        chk("rd_addr2", 32'(rf_rd_addr2), 32'd2);
        chk("add_ready", 32'(id_ready), 32'd1);
        tick();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs", ex_rs_val, 32'd5);
        chk("add_rt", ex_rt_val, 32'd9);
        chk("add_dst", 32'(ex_dst_addr), 32'd3);
        chk("add_op", 32'(ex_opcode), 32'h00);
        chk("add_funct", 32'(ex_funct), 32'h20);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_load", 32'(ex_is_load), 32'd0);
        chk("add_rsaddr", 32'(ex_rs_addr), 32'd1);

        // write-back bypass
        wb_wr_en = 1'b1; wb_wr_addr = 5'd1; wb_wr_data = 32'hAA;
        tick();
        chk("byp_rs", ex_rs_val, 32'hAA);
        chk("byp_rt", ex_rt_val, 32'd9);
        wb_wr_addr = 5'd0; wb_wr_data = 32'hFF;
        tick();
        chk("byp_r0_rs", ex_rs_val, 32'd5);
        offer(32'h00021820, 32'h104);
        tick();
        chk("rs0_val", ex_rs_val, 32'd0);
        wb_wr_en = 1'b0;

        // load-use bubble: LW r4,0(r1) then ADD r5,r4,r2
        offer(32'h8C240000, 32'h108);
        tick();
        chk("lw_load", 32'(ex_is_load), 32'd1);
        chk("lw_dst", 32'(ex_dst_addr), 32'd4);
        offer(32'h00822820, 32'h10C);
        #1;
        chk("hz_ready", 32'(id_ready), 32'd0);
        tick();
        chk("hz_bubble", 32'(ex_valid), 32'd0);
        chk("hz_ready2", 32'(id_ready), 32'd1);
        tick();
        chk("hz_valid", 32'(ex_valid), 32'd1);
        chk("hz_dst", 32'(ex_dst_addr), 32'd5);
        chk("hz_rs", ex_rs_val, 32'd7);
        chk("hz_pc", ex_pc, 32'h10C);

        // no dependence -> no bubble
        offer(32'h8C240000, 32'h110);
        tick();
        offer(32'h00C72820, 32'h114);
        #1;
        chk("nohz_ready", 32'(id_ready), 32'd1);
        tick();
        chk("nohz_valid", 32'(ex_valid), 32'd1);
        chk("nohz_pc", ex_pc, 32'h114);
        chk("nohz_rs", ex_rs_val, 32'h1006);

        // EX stall for 3 cycles
        ex_ready = 1'b0;
        offer(32'h20020005, 32'h200);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", 32'(id_ready), 32'd0);
            tick();
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_pc", ex_pc, 32'h114);
            chk("stall_dst", 32'(ex_dst_addr), 32'd5);
            chk("stall_rt", ex_rt_val, 32'h1007);
        end
        ex_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(id_ready), 32'd1);
        tick();
        chk("unstall_pc", ex_pc, 32'h200);
        chk("unstall_imm", ex_imm, 32'd5);
        chk("unstall_dst", 32'(ex_dst_addr), 32'd2);

        // flush with valid input and valid output
        flush = 1'b1;
        offer(32'h00221820, 32'h300);
        #1;
        chk("flush_ready", 32'(id_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_pc", ex_pc, 32'h200);
        flush = 1'b0;
        offer(32'h2002FFFF, 32'h400);
        tick();
        chk("addi_imm", ex_imm, 32'hFFFFFFFF);
        chk("addi_dst", 32'(ex_dst_addr), 32'd2);
        chk("addi_rs", ex_rs_val, 32'd0);

        // flush during EX stall
        ex_ready = 1'b0;
        flush = 1'b1;
        tick();
        chk("flush_stall", 32'(ex_valid), 32'd0);
        flush = 1'b0;
        ex_ready = 1'b1;

        // idle with free output
        offer(32'h00221820, 32'h500);
        tick();
        if_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(ex_valid), 32'd0);
        chk("idle_hold", ex_pc, 32'h500);

        // destination decode
        offer(32'hAC240000, 32'h600);
        tick();
        chk("sw_dst", 32'(ex_dst_addr), 32'd0);
        offer(32'h0C000010, 32'h604);
        tick();
        chk("jal_dst", 32'(ex_dst_addr), 32'd31);
        offer(32'h10220003, 32'h608);
        tick();
        chk("beq_dst", 32'(ex_dst_addr), 32'd0);
        chk("beq_imm", ex_imm, 32'd3);
        offer(32'h00221940, 32'h60C);
        tick();
        chk("shamt", 32'(ex_shamt), 32'd5);
        chk("sll_funct", 32'(ex_funct), 32'h00);

        // asynchronous reset mid-stream
        offer(32'h00221820, 32'h700);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_rs", ex_rs_val, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        if_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
